std_linear_sec_decoder_pipe: RTL and testbench
==============================================

// Module: std_linear_sec_decoder_pipe
// PURPOSE
//  Streaming, pipelined single-error-correcting (Hamming) decoder: the receive end of the
//  std_linear_sec_encoder. Accepts one K-bit codeword per beat on a valid/ready stream,
//  returns the N-bit data word with any single-bit error corrected, plus per-beat status
//  and a saturating corrected-error counter. Sits after memory/link readback.
// PARAMETERS
//  P        9                 parity bit count; N = 2**P-1-P data bits, K = 2**P-1 codeword bits
//  CNT_W    32                width of corrected-error counter
// PORTS
//  i_clk          in   1      clock, all state on rising edge
//  i_rst_n        in   1      asynchronous active-low reset
//  i_valid        in   1      input codeword valid
//  o_ready        out  1      decoder can accept a codeword
//  i_codeword     in   K      codeword, bit j = Hamming position j+1
//  o_valid        out  1      output beat valid
//  i_ready        in   1      downstream accepts output beat
//  o_word         out  N      corrected data word
//  o_corrected    out  1      beat had a nonzero syndrome (one bit flipped)
//  o_syndrome     out  P      raw syndrome of the beat
//  i_clear_count  in   1      synchronous clear of error counter
//  o_err_count    out  CNT_W  corrected beats since reset/clear, saturating
// BEHAVIOUR
//  - Code layout identical to encoder: parity at positions 2**i (i=0..P-1), data bits fill
//    remaining positions ascending (data bit 0 -> position 3). Syndrome bit i = XOR of all
//    codeword positions with bit i set. Syndrome s!=0 -> flip position s (bit s-1); since
//    K=2**P-1 every nonzero syndrome maps to a valid position (parity-only flips yield
//    unchanged data but o_corrected=1).
//  - Pipeline: S1 registers codeword + syndrome; S2 registers corrected word, flag,
//    syndrome. Latency 2 cycles from accepted input to o_valid with no stall.
//  - Handshake: transfer on valid&&ready at each side. S2 advances when !s2_v || i_ready;
//    S1 advances when !s1_v || S2 advances; o_ready = !s1_v || S1 advances. Full throughput
//    (1 beat/cycle) under continuous i_ready. o_ready may depend combinationally on
//    i_ready (no skid buffer).
//  - Output stability: while o_valid && !i_ready, o_word/o_corrected/o_syndrome held.
//  - Data registers have no reset; only s1_v, s2_v, counter reset.
//  - Counter: increments by 1 on each output transfer (o_valid&&i_ready) with
//    o_corrected=1; saturates at 2**CNT_W-1. i_clear_count same cycle as increment:
//    clear wins, result 0.
//  - Reset (any time, incl. mid-stream): o_valid=0, o_ready=1 after deassert only when
//    pipe empty, o_err_count=0, in-flight beats discarded; o_word/o_syndrome don't-care.
//  - Double-bit errors are not detected: miscorrected word with o_corrected=1 (SEC only).
// STRUCTURE
//  - Shared package std_linear_sec_pkg: functions sec_n(P), sec_k(P), is_pow2(pos),
//    data_pos(idx) mapping data index -> codeword position; used by encoder and this block.
//  - Sub-module std_linear_sec_syndrome (combinational, P-bit syndrome from K-bit codeword),
//    instanced once in S1; correction mux + handshake + counter in this module.
//  - Formal harness: encoder -> onehot0 error inject -> this block; assert o_word equals
//    word fed 2 accepted beats earlier, o_corrected == onehot(err).
// TESTING  (P=4: N=11, K=15)
//  - Encode 11'h5A3, no error, i_ready=1 -> o_word=11'h5A3 two cycles later, o_corrected=0,
//    o_syndrome=0, count stays 0.
//  - Same word, flip bit 6 (position 7) -> o_word=11'h5A3, o_corrected=1, o_syndrome=4'd7,
//    count=1 after transfer.
//  - Flip bit 7 (position 8, parity) -> o_word correct, o_syndrome=4'd8, o_corrected=1.
//  - 8 back-to-back beats, i_ready low cycles 3-5 -> o_ready low once pipe full, outputs
//    held stable, all 8 delivered in order, none lost/duplicated.
//  - Counter preset near saturation (CNT_W=2), 5 corrected beats -> o_err_count stops at 3;
//    clear coincident with a corrected transfer -> 0.
//  - Assert i_rst_n low with 2 beats in flight -> o_valid=0 immediately, count=0, no stale
//    beat emitted after release.

Source files
------------

// File: rtl/std_linear_sec_pkg.sv
// Shared helpers for the linear single-error-correcting (Hamming) encoder/decoder family.
// Parity bits sit at power-of-two positions; data bits fill the remaining positions ascending.
package std_linear_sec_pkg;

    // Number of data bits carried by a code with p parity bits.
    function automatic int sec_n(input int p);
        return (1 << p) - 1 - p;
    endfunction

    // Number of codeword bits for a code with p parity bits.
    function automatic int sec_k(input int p);
        return (1 << p) - 1;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // 1-based codeword position of data bit idx: skip every parity slot at or below it.
    function automatic int data_pos(input int idx);
        int pos;
        pos = idx + 1;
        for (int i = 0; i < 30; i++) begin
            if ((1 << i) <= pos) begin
                pos = pos + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/std_linear_sec_syndrome.sv
// Combinational Hamming syndrome: bit i is the XOR of every codeword position with bit i set.
module std_linear_sec_syndrome
    import std_linear_sec_pkg::*;
#(
    parameter int P = 9,
    localparam int K = sec_k(P)
) (
    input  logic [K-1:0] codeword_i,
    output logic [P-1:0] syndrome_o
);

    always_comb begin
        syndrome_o = '0;
        for (int j = 0; j < K; j++) begin
            for (int i = 0; i < P; i++) begin
                if ((((j + 1) >> i) & 1) != 0) begin
                    syndrome_o[i] = syndrome_o[i] ^ codeword_i[j];
                end
            end
        end
    end

endmodule

// File: rtl/std_linear_sec_decoder_pipe.sv
// Two-stage streaming SEC decoder: S1 holds syndrome + data bits, S2 holds the corrected word.
// Valid/ready on both sides, full throughput, saturating count of corrected beats.
module std_linear_sec_decoder_pipe
    import std_linear_sec_pkg::*;
#(
    parameter int P     = 9,
    parameter int CNT_W = 32,
    localparam int N    = sec_n(P),
    localparam int K    = sec_k(P)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [K-1:0]     i_codeword,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_word,
    output logic             o_corrected,
    output logic [P-1:0]     o_syndrome,
    input  logic             i_clear_count,
    output logic [CNT_W-1:0] o_err_count
);

    logic             s1Valid_q, s1Valid_d;
    logic             s2Valid_q, s2Valid_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;

    logic [N-1:0]     s1Data_q;
    logic [P-1:0]     s1Syn_q;
    logic [N-1:0]     s2Word_q;
    logic             s2Corr_q;
    logic [P-1:0]     s2Syn_q;

    logic [P-1:0]     inSyn;
    logic [N-1:0]     inData;
    logic [N-1:0]     fixWord;

    logic             s2Adv;
    logic             s1Adv;
    logic             inXfer;
    logic             outXfer;

    std_linear_sec_syndrome #(
        .P(P)
    ) u_syndrome (
        .codeword_i (i_codeword),
        .syndrome_o (inSyn)
    );

    // Parity positions are not carried into S1: flipping one never changes the data word.
    for (genvar d = 0; d < N; d++) begin : g_data
        localparam int Pos = data_pos(d);
        assign inData[d]  = i_codeword[Pos-1];
        assign fixWord[d] = s1Data_q[d] ^ (s1Syn_q == P'(Pos));
    end

    assign s2Adv   = !s2Valid_q || i_ready;
    assign s1Adv   = !s1Valid_q || s2Adv;
    assign o_ready = !s1Valid_q || s1Adv;
    assign inXfer  = i_valid && o_ready;
    assign outXfer = s2Valid_q && i_ready;

    always_comb begin
        s1Valid_d = s1Valid_q;
        s2Valid_d = s2Valid_q;
        errCnt_d  = errCnt_q;
        if (s1Adv) begin
            s1Valid_d = i_valid;
        end
        if (s2Adv) begin
            s2Valid_d = s1Valid_q;
        end
        if (i_clear_count) begin
            errCnt_d = '0;
        end else if (outXfer && s2Corr_q && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            errCnt_q  <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s2Valid_q <= s2Valid_d;
            errCnt_q  <= errCnt_d;
        end
    end

    // Payload registers are qualified by the valid bits, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (inXfer) begin
            s1Data_q <= inData;
            s1Syn_q  <= inSyn;
        end
        if (s2Adv && s1Valid_q) begin
            s2Word_q <= fixWord;
            s2Corr_q <= |s1Syn_q;
            s2Syn_q  <= s1Syn_q;
        end
    end

    assign o_valid     = s2Valid_q;
    assign o_word      = s2Word_q;
    assign o_corrected = s2Corr_q;
    assign o_syndrome  = s2Syn_q;
    assign o_err_count = errCnt_q;

endmodule

// File: tb/tb_std_linear_sec_decoder_pipe.sv
// Directed bench for the pipelined SEC decoder at P=4 (11 data bits, 15-bit codeword), 2-bit counter.
module tb_std_linear_sec_decoder_pipe;

    localparam int P     = 4;
    localparam int CNT_W = 2;
    localparam int N     = 11;
    localparam int K     = 15;

    localparam logic [N-1:0] WORD_5A3 = 11'h5A3;
    localparam logic [K-1:0] CW_5A3   = 15'h5A16;

    logic             clock = 1'b0;
    logic             rstN = 1'b0;
    logic             inValid = 1'b0;
    logic             outReady;
    logic [K-1:0]     inCodeword = '0;
    logic             outValid;
    logic             inReady = 1'b1;
    logic [N-1:0]     outWord;
    logic             outCorrected;
    logic [P-1:0]     outSyndrome;
    logic             clearCount = 1'b0;
    logic [CNT_W-1:0] errCount;

    int checks = 0;
    int failures = 0;

    std_linear_sec_decoder_pipe #(
        .P(P),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk         (clock),
        .i_rst_n       (rstN),
        .i_valid       (inValid),
        .o_ready       (outReady),
        .i_codeword    (inCodeword),
        .o_valid       (outValid),
        .i_ready       (inReady),
        .o_word        (outWord),
        .o_corrected   (outCorrected),
        .o_syndrome    (outSyndrome),
        .i_clear_count (clearCount),
        .o_err_count   (errCount)
    );

    always #5 clock = ~clock;

    // Reference encoder: data bits fill non-power-of-two positions, then even parity per bit.
    function automatic logic [K-1:0] encode(input logic [N-1:0] data);
        logic [K-1:0] cw;
        logic         par;
        int           idx;
        cw  = '0;
        idx = 0;
        for (int pos = 1; pos <= K; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = data[idx];
                idx++;
            end
        end
        for (int i = 0; i < P; i++) begin
            par = 1'b0;
            for (int pos = 1; pos <= K; pos++) begin
                if (((pos >> i) & 1) != 0) par = par ^ cw[pos-1];
            end
            cw[(1 << i) - 1] = par;
        end
        return cw;
    endfunction

    // Drives one beat; returns at the negedge where that beat should sit on the output.
    task automatic pushBeat(input logic [K-1:0] cw);
        @(negedge clock);
        inValid    = 1'b1;
        inCodeword = cw;
        @(negedge clock);
        inValid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (outValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid: got %b want 0", outValid);
        end
        checks++;
        if (outReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b want 1", outReady);
        end
        checks++;
        if (errCount !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_count: got %0d want 0", errCount);
        end
        rstN = 1'b1;
        @(negedge clock);
        checks++;
        if (outValid !== 1'b0 || outReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_idle: got valid=%b ready=%b want valid=0 ready=1", outValid, outReady);
        end
    endtask

    task automatic test_clean();
        @(negedge clock);
        inValid    = 1'b1;
        inCodeword = CW_5A3;
        #1;
        checks++;
        if (outReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clean_ready: got %b want 1", outReady);
        end
        @(negedge clock);
        inValid = 1'b0;
        checks++;
        if (outValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clean_latency1: got valid=%b want 0", outValid);
        end
        @(negedge clock);
        checks++;
        if (outValid !== 1'b1 || outWord !== WORD_5A3) begin
            failures++;
            $display("[TB] FAIL clean_word: got valid=%b word=%h want valid=1 word=%h", outValid, outWord, WORD_5A3);
        end
        checks++;
        if (outCorrected !== 1'b0 || outSyndrome !== 4'd0) begin
            failures++;
            $display("[TB] FAIL clean_status: got corr=%b syn=%0d want corr=0 syn=0", outCorrected, outSyndrome);
        end
        @(negedge clock);
        checks++;
        if (outValid !== 1'b0 || errCount !== 2'd0) begin
            failures++;
            $display("[TB] FAIL clean_after: got valid=%b count=%0d want valid=0 count=0", outValid, errCount);
        end
    endtask

    task automatic test_single_error();
        pushBeat(CW_5A3 ^ 15'h0040);
        checks++;
        if (outValid !== 1'b1 || outWord !== WORD_5A3) begin
            failures++;
            $display("[TB] FAIL data_flip_word: got valid=%b word=%h want valid=1 word=%h", outValid, outWord, WORD_5A3);
        end
        checks++;
        if (outCorrected !== 1'b1 || outSyndrome !== 4'd7) begin
            failures++;
            $display("[TB] FAIL data_flip_status: got corr=%b syn=%0d want corr=1 syn=7", outCorrected, outSyndrome);
        end
        @(negedge clock);
        checks++;
        if (errCount !== 2'd1) begin
            failures++;
            $display("[TB] FAIL data_flip_count: got %0d want 1", errCount);
        end
    endtask

    task automatic test_parity_error();
        pushBeat(CW_5A3 ^ 15'h0080);
        checks++;
        if (outValid !== 1'b1 || outWord !== WORD_5A3) begin
            failures++;
            $display("[TB] FAIL parity_flip_word: got valid=%b word=%h want valid=1 word=%h", outValid, outWord, WORD_5A3);
        end
        checks++;
        if (outCorrected !== 1'b1 || outSyndrome !== 4'd8) begin
            failures++;
            $display("[TB] FAIL parity_flip_status: got corr=%b syn=%0d want corr=1 syn=8", outCorrected, outSyndrome);
        end
        @(negedge clock);
        checks++;
        if (errCount !== 2'd2) begin
            failures++;
            $display("[TB] FAIL parity_flip_count: got %0d want 2", errCount);
        end
    endtask

    task automatic test_last_position();
        pushBeat(CW_5A3 ^ 15'h4000);
        checks++;
        if (outWord !== WORD_5A3 || outCorrected !== 1'b1 || outSyndrome !== 4'd15) begin
            failures++;
            $display("[TB] FAIL top_flip: got word=%h corr=%b syn=%0d want word=%h corr=1 syn=15", outWord, outCorrected, outSyndrome, WORD_5A3);
        end
        @(negedge clock);
        checks++;
        if (errCount !== 2'd3) begin
            failures++;
            $display("[TB] FAIL top_flip_count: got %0d want 3", errCount);
        end
    endtask

    // Positions 3 and 5 flipped alias to syndrome 6, so data bit 2 is wrongly flipped as well.
    task automatic test_double_error();
        pushBeat(CW_5A3 ^ 15'h0014);
        checks++;
        if (outWord !== 11'h5A4 || outCorrected !== 1'b1 || outSyndrome !== 4'd6) begin
            failures++;
            $display("[TB] FAIL double_flip: got word=%h corr=%b syn=%0d want word=5a4 corr=1 syn=6", outWord, outCorrected, outSyndrome);
        end
        @(negedge clock);
        checks++;
        if (errCount !== 2'd3) begin
            failures++;
            $display("[TB] FAIL double_flip_saturate: got %0d want 3", errCount);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] words [8];
        int           flips [8];
        logic [K-1:0] cws   [8];
        logic [P-1:0] expSyn;
        int           txIdx;
        int           rxIdx;
        int           cyc;
        logic         sawReadyLow;
        logic         wasStalled;

        words = '{11'h001, 11'h7FF, 11'h2AA, 11'h555, 11'h123, 11'h456, 11'h0F0, 11'h70F};
        flips = '{-1, 0, 14, 6, -1, 3, 7, 10};
        for (int k = 0; k < 8; k++) begin
            cws[k] = encode(words[k]);
            if (flips[k] >= 0) cws[k] = cws[k] ^ (15'(1) << flips[k]);
        end
        txIdx       = 0;
        rxIdx       = 0;
        cyc         = 0;
        sawReadyLow = 1'b0;
        wasStalled  = 1'b0;

        while (rxIdx < 8 && cyc < 40) begin
            @(negedge clock);
            inReady = !(cyc >= 3 && cyc <= 5);
            if (txIdx < 8) begin
                inValid    = 1'b1;
                inCodeword = cws[txIdx];
            end else begin
                inValid = 1'b0;
            end
            #1;
            if (!outReady) sawReadyLow = 1'b1;
            if (wasStalled) begin
                checks++;
                if (outValid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_hold_valid: cycle %0d got valid=%b want 1", cyc, outValid);
                end
            end
            if (outValid === 1'b1) begin
                expSyn = (flips[rxIdx] >= 0) ? P'(flips[rxIdx] + 1) : '0;
                checks++;
                if (outWord !== words[rxIdx] || outCorrected !== (flips[rxIdx] >= 0) || outSyndrome !== expSyn) begin
                    failures++;
                    $display("[TB] FAIL b2b_beat%0d: got word=%h corr=%b syn=%0d want word=%h corr=%b syn=%0d",
                             rxIdx, outWord, outCorrected, outSyndrome, words[rxIdx], (flips[rxIdx] >= 0), expSyn);
                end
                wasStalled = !inReady;
                if (inReady) rxIdx++;
            end else begin
                wasStalled = 1'b0;
            end
            if (inValid && outReady) txIdx++;
            cyc++;
        end
        @(negedge clock);
        inValid = 1'b0;
        inReady = 1'b1;
        checks++;
        if (rxIdx != 8) begin
            failures++;
            $display("[TB] FAIL b2b_delivered: got %0d beats want 8", rxIdx);
        end
        checks++;
        if (!sawReadyLow) begin
            failures++;
            $display("[TB] FAIL b2b_backpressure: got ready never low want low while stalled");
        end
        repeat (3) begin
            #1;
            checks++;
            if (outValid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_extra_beat: got valid=%b want 0", outValid);
            end
            @(negedge clock);
        end
        checks++;
        if (errCount !== 2'd3) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d want 3", errCount);
        end
    endtask

    task automatic test_clear();
        @(negedge clock);
        clearCount = 1'b1;
        @(negedge clock);
        clearCount = 1'b0;
        checks++;
        if (errCount !== 2'd0) begin
            failures++;
            $display("[TB] FAIL clear: got %0d want 0", errCount);
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] expCount [5];
        expCount = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int k = 0; k < 5; k++) begin
            pushBeat(CW_5A3 ^ (15'(1) << (k * 3)));
            checks++;
            if (outValid !== 1'b1 || outWord !== WORD_5A3 || outCorrected !== 1'b1) begin
                failures++;
                $display("[TB] FAIL sat_beat%0d: got valid=%b word=%h corr=%b want valid=1 word=%h corr=1",
                         k, outValid, outWord, outCorrected, WORD_5A3);
            end
            @(negedge clock);
            checks++;
            if (errCount !== expCount[k]) begin
                failures++;
                $display("[TB] FAIL sat_count%0d: got %0d want %0d", k, errCount, expCount[k]);
            end
        end
    endtask

    task automatic test_clear_coincident();
        pushBeat(CW_5A3 ^ 15'h0200);
        clearCount = 1'b1;
        @(negedge clock);
        clearCount = 1'b0;
        checks++;
        if (errCount !== 2'd0) begin
            failures++;
            $display("[TB] FAIL clear_wins: got %0d want 0", errCount);
        end
        pushBeat(CW_5A3 ^ 15'h0001);
        @(negedge clock);
        checks++;
        if (errCount !== 2'd1) begin
            failures++;
            $display("[TB] FAIL count_after_clear: got %0d want 1", errCount);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clock);
        inValid    = 1'b1;
        inCodeword = CW_5A3 ^ 15'h0002;
        @(negedge clock);
        inCodeword = encode(11'h3C3) ^ 15'h0100;
        @(negedge clock);
        inValid = 1'b0;
        checks++;
        if (outValid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midstream_inflight: got valid=%b want 1", outValid);
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0 || errCount !== 2'd0) begin
            failures++;
            $display("[TB] FAIL midstream_reset: got valid=%b count=%0d want valid=0 count=0", outValid, errCount);
        end
        checks++;
        if (outReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midstream_ready: got %b want 1", outReady);
        end
        @(negedge clock);
        @(negedge clock);
        rstN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if (outValid !== 1'b0 || outReady !== 1'b1) begin
                failures++;
                $display("[TB] FAIL midstream_stale%0d: got valid=%b ready=%b want valid=0 ready=1", c, outValid, outReady);
            end
        end
        checks++;
        if (errCount !== 2'd0) begin
            failures++;
            $display("[TB] FAIL midstream_count: got %0d want 0", errCount);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_parity_error();
        test_last_position();
        test_double_error();
        test_back_to_back();
        test_clear();
        test_saturation();
        test_clear_coincident();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
